// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Op encoding and chunk-width derivation live here so every file agrees on them.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Guarded so a bad STAGES value reaches the elaboration check instead of dividing by zero.
    function automatic int calc_cw(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CW-bit ripple-carry adder; one instance resolves one pipeline chunk.
// Also exposes the carry into the chunk MSB so the top stage can form signed overflow.
module addsub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout,
    output logic          c_msb_in
);

    logic carry;

    always_comb begin
        carry    = cin;
        c_msb_in = cin;
        sum      = '0;
        for (int i = 0; i < CW; i++) begin
            if (i == CW - 1) begin
                c_msb_in = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit adder/subtractor whose carry chain is cut into STAGES chunks, one resolved per clock.
// Global-enable pipeline: every stage advances together whenever the output is free or drained.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW   = calc_cw(WIDTH, STAGES);
    localparam int NS   = (STAGES < 1) ? 1 : STAGES;
    localparam int LAST = NS - 1;

    generate
        if ((STAGES < 1) || ((WIDTH % NS) != 0) || (TAG_W < 1)) begin : g_param_guard
            $error("pipelined_addsub: WIDTH must be a multiple of STAGES, STAGES >= 1, TAG_W >= 1");
        end
    endgenerate

    // Combinational inputs seen by each stage (from the input port or the previous bank)
    logic [WIDTH-1:0] stg_a   [NS];
    logic [WIDTH-1:0] stg_b   [NS];
    logic [WIDTH-1:0] stg_res [NS];
    logic             stg_c   [NS];
    logic             stg_v   [NS];
    logic [TAG_W-1:0] stg_tag [NS];

    logic [CW-1:0]    chunk_sum  [NS];
    logic             chunk_cout [NS];
    logic             chunk_cmsb [NS];
    logic [WIDTH-1:0] res_d      [NS];

    // Stage register banks
    logic [WIDTH-1:0] a_q   [NS];
    logic [WIDTH-1:0] b_q   [NS];
    logic [WIDTH-1:0] res_q [NS];
    logic             c_q   [NS];
    logic             v_q   [NS];
    logic [TAG_W-1:0] tag_q [NS];
    logic             ovf_q;
    logic             zero_q;
    logic             ovf_d;
    logic             zero_d;

    logic             adv;
    logic [WIDTH-1:0] b_sel;
    logic             c_sel;

    // Subtract is a + ~b + ~cin, so a borrow-in of 1 becomes a carry-in of 0.
    assign b_sel = (op == OP_SUB) ? ~b   : b;
    assign c_sel = (op == OP_SUB) ? ~cin : cin;

    assign adv      = out_ready || !v_q[LAST];
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < NS; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stg_a[gi]   = a;
                assign stg_b[gi]   = b_sel;
                assign stg_c[gi]   = c_sel;
                assign stg_res[gi] = '0;
                assign stg_v[gi]   = in_valid;
                assign stg_tag[gi] = tag;
            end else begin : g_body
                assign stg_a[gi]   = a_q[gi-1];
                assign stg_b[gi]   = b_q[gi-1];
                assign stg_c[gi]   = c_q[gi-1];
                assign stg_res[gi] = res_q[gi-1];
                assign stg_v[gi]   = v_q[gi-1];
                assign stg_tag[gi] = tag_q[gi-1];
            end

            addsub_chunk #(
                .CW(CW)
            ) u_chunk (
                .a        (stg_a[gi][gi*CW +: CW]),
                .b        (stg_b[gi][gi*CW +: CW]),
                .cin      (stg_c[gi]),
                .sum      (chunk_sum[gi]),
                .cout     (chunk_cout[gi]),
                .c_msb_in (chunk_cmsb[gi])
            );

            // Bits above the current chunk are still zero, so OR-ing places the new chunk.
            assign res_d[gi] = stg_res[gi] | (WIDTH'(chunk_sum[gi]) << (gi * CW));
        end
    endgenerate

    assign ovf_d  = chunk_cout[LAST] ^ chunk_cmsb[LAST];
    assign zero_d = (res_d[LAST] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NS; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
                c_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                tag_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NS; k++) begin
                a_q[k]   <= stg_a[k];
                b_q[k]   <= stg_b[k];
                res_q[k] <= res_d[k];
                c_q[k]   <= chunk_cout[k];
                v_q[k]   <= stg_v[k];
                tag_q[k] <= stg_tag[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = res_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised and directed bench for pipelined_addsub against an integer-arithmetic reference.
// A negedge monitor tracks each accepted op's age and checks every output cycle.
module tb_pipelined_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
    localparam int TAG_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             op_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] out_tag;

    int checks = 0;
    int errors = 0;

    // Directed expectations riding along with the current input
    logic             drv_dir = 1'b0;
    logic [WIDTH-1:0] drv_dsum;
    logic             drv_dcout, drv_dovf, drv_dzero;
    bit               rand_done;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic [TAG_W-1:0] tag;
        int               age;
        bit               has_dir;
        logic [WIDTH-1:0] dsum;
        logic             dcout;
        logic             dovf;
        logic             dzero;
    } exp_t;

    exp_t q[$];

    pipelined_addsub #(
        .WIDTH (WIDTH),
        .STAGES(STAGES),
        .TAG_W (TAG_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a_in),
        .b        (b_in),
        .cin      (cin_in),
        .op       (op_in),
        .tag      (tag_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, obs, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mc, input logic mop, input logic [TAG_W-1:0] mt);
        exp_t e;
        int   ua, ub, sa, sb, r, sr;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (mop == 1'b0) begin
            r      = ua + ub + int'(mc);
            sr     = sa + sb + int'(mc);
            e.cout = (r > 65535);
        end else begin
            r      = ua - ub - int'(mc);
            sr     = sa - sb - int'(mc);
            e.cout = (r >= 0);
        end
        e.sum     = r[WIDTH-1:0];
        e.ovf     = (sr > 32767) || (sr < -32768);
        e.zero    = (e.sum == '0);
        e.tag     = mt;
        e.age     = 1;
        e.has_dir = 1'b0;
        e.dsum    = '0;
        e.dcout   = 1'b0;
        e.dovf    = 1'b0;
        e.dzero   = 1'b0;
        return e;
    endfunction

    // Predicts the coming posedge from values stable at the negedge.
    always @(negedge clk) begin
        bit   exp_v;
        bit   adv_m;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            check_val("rst_out_valid", 32'(out_valid), 32'd0);
            check_val("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            exp_v = (q.size() > 0) && (q[0].age == STAGES);
            check_val("out_valid", 32'(out_valid), 32'(exp_v));
            adv_m = out_ready || !exp_v;
            check_val("in_ready", 32'(in_ready), 32'(adv_m));
            if (exp_v) begin
                check_val("sum", 32'(sum), 32'(q[0].sum));
                check_val("cout", 32'(cout), 32'(q[0].cout));
                check_val("ovf", 32'(ovf), 32'(q[0].ovf));
                check_val("zero", 32'(zero), 32'(q[0].zero));
                check_val("out_tag", 32'(out_tag), 32'(q[0].tag));
                if (q[0].has_dir) begin
                    check_val("dir_sum", 32'(sum), 32'(q[0].dsum));
                    check_val("dir_cout", 32'(cout), 32'(q[0].dcout));
                    check_val("dir_ovf", 32'(ovf), 32'(q[0].dovf));
                    check_val("dir_zero", 32'(zero), 32'(q[0].dzero));
                end
                if (out_ready) begin
                    $display("result tag=%0d sum=0x%04h cout=%0d ovf=%0d zero=%0d",
                             out_tag, sum, cout, ovf, zero);
                end
            end
            if (adv_m) begin
                if (exp_v && out_ready) begin
                    void'(q.pop_front());
                end
                foreach (q[i]) q[i].age++;
                if (in_valid) begin
                    e         = model(a_in, b_in, cin_in, op_in, tag_in);
                    e.has_dir = drv_dir;
                    e.dsum    = drv_dsum;
                    e.dcout   = drv_dcout;
                    e.dovf    = drv_dovf;
                    e.dzero   = drv_dzero;
                    q.push_back(e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                        input logic tc, input logic top, input logic [TAG_W-1:0] tt);
        bit acc;
        a_in     = ta;
        b_in     = tb2;
        cin_in   = tc;
        op_in    = top;
        tag_in   = tt;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        drv_dir  = 1'b0;
        a_in     = WIDTH'($urandom);
        b_in     = WIDTH'($urandom);
    endtask

    task automatic send_dir(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2,
                            input logic tc, input logic top, input logic [TAG_W-1:0] tt,
                            input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                            input logic ez);
        drv_dir   = 1'b1;
        drv_dsum  = es;
        drv_dcout = ec;
        drv_dovf  = eo;
        drv_dzero = ez;
        send(ta, tb2, tc, top, tt);
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check_val("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;
        op_in     = 1'b0;
        tag_in    = '0;
        rand_done = 1'b0;

        @(posedge clk);
        #2;
        check_val("reset_sum", 32'(sum), 32'd0);
        check_val("reset_cout", 32'(cout), 32'd0);
        check_val("reset_ovf", 32'(ovf), 32'd0);
        check_val("reset_zero", 32'(zero), 32'd0);
        check_val("reset_tag", 32'(out_tag), 32'd0);
        check_val("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed arithmetic cases
        send_dir(16'h1234, 16'h4321, 1'b0, 1'b0, 4'd5, 16'h5555, 1'b0, 1'b0, 1'b0);
        drain();
        send_dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b0, 1'b1);
        send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd2, 16'h8000, 1'b0, 1'b1, 1'b0);
        send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 4'd3, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd4, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send_dir(16'h0000, 16'h0000, 1'b1, 1'b1, 4'd6, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        send_dir(16'h1234, 16'h1234, 1'b0, 1'b1, 4'd7, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), TAG_W'(i));
        end
        drain();

        // Backpressure: hold out_ready low for 3 cycles once a result appears
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                         TAG_W'(8 + i));
                end
            end
            begin
                for (int n = 0; n < 40 && !out_valid; n++) begin
                    @(posedge clk);
                    #1;
                end
                check_val("bp_saw_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Mid-flight reset with three ops in the pipe, the oldest at the output
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 4'd1);
        send(16'h3333, 16'h4444, 1'b0, 1'b0, 4'd2);
        send(16'h5555, 16'h6666, 1'b0, 1'b0, 4'd3);
        @(posedge clk);
        #2;
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'd0);
        check_val("async_rst_sum", 32'(sum), 32'd0);
        check_val("async_rst_tag", 32'(out_tag), 32'd0);
        check_val("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_dir(16'h00FF, 16'h0F01, 1'b0, 1'b0, 4'd9, 16'h1000, 1'b0, 1'b0, 1'b0);
        drain();

        // Random traffic with random gaps and random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
                         TAG_W'($urandom));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #0;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
